// File: rtl/timer_counter.sv
// Counting core of the 8-bit APB timer: prescaled up/down counter with sticky wrap flags.
// Optional registered interrupt output is built only when TIMER_IRQ_EN is defined.
module timer_counter #(
    parameter int WIDTH   = 8,
    parameter int PRESC_W = 4
) (
    input  logic             PCLK,
    input  logic             PRESETn,
    input  logic [7:0]       tcr,
    input  logic [WIDTH-1:0] tdr,
    input  logic [1:0]       flag_clr,
    output logic [WIDTH-1:0] cnt,
    output logic             ovf,
    output logic             udf,
    output logic [7:0]       tsr_status,
    output logic             irq
);

    localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);
    localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] CNT_MIN = '0;

    logic               tcr_load;
    logic               tcr_dir;
    logic               tcr_en;
    logic [1:0]         tcr_cks;

    logic [PRESC_W-1:0] presc_q;
    logic [PRESC_W-1:0] presc_d;
    logic               load_prev_q;
    logic               load_prev_d;
    logic [WIDTH-1:0]   cnt_q;
    logic [WIDTH-1:0]   cnt_d;
    logic               ovf_q;
    logic               ovf_d;
    logic               udf_q;
    logic               udf_d;
    logic               irq_q;
    logic               irq_d;

    logic [PRESC_W-1:0] presc_mask;
    logic               tick;
    logic               load_pulse;
    logic               ovf_set;
    logic               udf_set;

    assign tcr_load = tcr[7];
    assign tcr_dir  = tcr[5];
    assign tcr_en   = tcr[4];
    assign tcr_cks  = tcr[1:0];

`ifdef TIMER_IRQ_EN
    logic unused_tcr_bits;
    assign unused_tcr_bits = tcr[6];
`else
    logic unused_tcr_bits;
    assign unused_tcr_bits = ^{tcr[6], tcr[3:2]};
`endif

    // Low (cks+1) prescaler bits must all be ones for a tick.
    always_comb begin
        presc_mask = PRESC_W'(1);
        case (tcr_cks)
            2'b00:   presc_mask = PRESC_W'(1);
            2'b01:   presc_mask = PRESC_W'(3);
            2'b10:   presc_mask = PRESC_W'(7);
            default: presc_mask = PRESC_W'(15);
        endcase
    end

    assign tick       = tcr_en && ((presc_q & presc_mask) == presc_mask);
    assign load_pulse = tcr_load && !load_prev_q;
    assign ovf_set    = tick && !load_pulse && !tcr_dir && (cnt_q == CNT_MAX);
    assign udf_set    = tick && !load_pulse &&  tcr_dir && (cnt_q == CNT_MIN);

    always_comb begin
        load_prev_d = tcr_load;

        presc_d = presc_q;
        if (load_pulse || !tcr_en) begin
            presc_d = '0;
        end else begin
            presc_d = presc_q + PRESC_W'(1);
        end

        cnt_d = cnt_q;
        if (load_pulse) begin
            cnt_d = tdr;
        end else if (tick) begin
            cnt_d = tcr_dir ? (cnt_q - CNT_ONE) : (cnt_q + CNT_ONE);
        end

        // A wrap in the same cycle as a clear pulse keeps the flag set.
        ovf_d = ovf_set || (ovf_q && !flag_clr[0]);
        udf_d = udf_set || (udf_q && !flag_clr[1]);

`ifdef TIMER_IRQ_EN
        irq_d = (ovf_d && tcr[3]) || (udf_d && tcr[2]);
`else
        irq_d = 1'b0;
`endif
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            presc_q     <= '0;
            load_prev_q <= 1'b0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            udf_q       <= 1'b0;
            irq_q       <= 1'b0;
        end else begin
            presc_q     <= presc_d;
            load_prev_q <= load_prev_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            udf_q       <= udf_d;
            irq_q       <= irq_d;
        end
    end

    assign cnt        = cnt_q;
    assign ovf        = ovf_q;
    assign udf        = udf_q;
    assign irq        = irq_q;
    assign tsr_status = {6'b0, udf_q, ovf_q};

endmodule

// File: tb/tb_timer_counter.sv
// Directed self-checking bench for timer_counter; irq expectations follow TIMER_IRQ_EN.
module tb_timer_counter;

`ifdef TIMER_IRQ_EN
    localparam bit IRQ_ON = 1'b1;
`else
    localparam bit IRQ_ON = 1'b0;
`endif

    logic       PCLK;
    logic       PRESETn;
    logic [7:0] tcr;
    logic [7:0] tdr;
    logic [1:0] flag_clr;
    logic [7:0] cnt;
    logic       ovf;
    logic       udf;
    logic [7:0] tsr_status;
    logic       irq;

    int checks;
    int failures;

    timer_counter #(.WIDTH(8), .PRESC_W(4)) dut (
        .PCLK       (PCLK),
        .PRESETn    (PRESETn),
        .tcr        (tcr),
        .tdr        (tdr),
        .flag_clr   (flag_clr),
        .cnt        (cnt),
        .ovf        (ovf),
        .udf        (udf),
        .tsr_status (tsr_status),
        .irq        (irq)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    // Advance n rising edges and settle 1 ns past the last one.
    task automatic step(input int n);
        repeat (n) @(posedge PCLK);
        #1;
    endtask

    task automatic do_reset();
        @(posedge PCLK);
        #1;
        tcr      = 8'h00;
        tdr      = 8'h00;
        flag_clr = 2'b00;
        PRESETn  = 1'b0;
        #3;
        PRESETn  = 1'b1;
        @(posedge PCLK);
        #1;
    endtask

    task automatic test_reset();
        checks++;
        if (cnt !== 8'h00 || ovf !== 1'b0 || udf !== 1'b0 || irq !== 1'b0 || tsr_status !== 8'h00) begin
            $display("[TB] FAIL reset_init cnt=%h ovf=%b udf=%b irq=%b tsr=%h exp all zero", cnt, ovf, udf, irq, tsr_status);
            failures++;
        end
        tdr = 8'h37;
        tcr = 8'h80;
        step(1);
        tcr = 8'h10;
        step(1);
        checks++;
        if (cnt !== 8'h37) begin
            $display("[TB] FAIL reset_preload cnt=%h exp=37", cnt);
            failures++;
        end
        #2;
        PRESETn = 1'b0;
        #1;
        checks++;
        if (cnt !== 8'h00 || ovf !== 1'b0 || udf !== 1'b0 || irq !== 1'b0) begin
            $display("[TB] FAIL reset_async cnt=%h ovf=%b udf=%b irq=%b exp all zero", cnt, ovf, udf, irq);
            failures++;
        end
        #2;
        PRESETn = 1'b1;
        step(1);
        checks++;
        if (cnt !== 8'h00) begin
            $display("[TB] FAIL reset_first_edge cnt=%h exp=00", cnt);
            failures++;
        end
        step(1);
        checks++;
        if (cnt !== 8'h01) begin
            $display("[TB] FAIL reset_resume cnt=%h exp=01", cnt);
            failures++;
        end
    endtask

    task automatic test_prescale();
        do_reset();
        tcr = 8'h11;
        step(3);
        checks++;
        if (cnt !== 8'h00) begin
            $display("[TB] FAIL div4_edge3 cnt=%h exp=00", cnt);
            failures++;
        end
        step(1);
        checks++;
        if (cnt !== 8'h01) begin
            $display("[TB] FAIL div4_edge4 cnt=%h exp=01", cnt);
            failures++;
        end
        step(8);
        checks++;
        if (cnt !== 8'h03) begin
            $display("[TB] FAIL div4_edge12 cnt=%h exp=03", cnt);
            failures++;
        end
        do_reset();
        tcr = 8'h10;
        step(12);
        checks++;
        if (cnt !== 8'h06) begin
            $display("[TB] FAIL div2_edge12 cnt=%h exp=06", cnt);
            failures++;
        end
    endtask

    task automatic test_overflow();
        do_reset();
        tdr = 8'hFE;
        tcr = 8'h80;
        step(1);
        tcr = 8'h10;
        checks++;
        if (cnt !== 8'hFE || ovf !== 1'b0) begin
            $display("[TB] FAIL ovf_load cnt=%h ovf=%b exp cnt=fe ovf=0", cnt, ovf);
            failures++;
        end
        step(2);
        checks++;
        if (cnt !== 8'hFF || ovf !== 1'b0) begin
            $display("[TB] FAIL ovf_pre cnt=%h ovf=%b exp cnt=ff ovf=0", cnt, ovf);
            failures++;
        end
        step(2);
        checks++;
        if (cnt !== 8'h00 || ovf !== 1'b1 || tsr_status !== 8'h01 || udf !== 1'b0) begin
            $display("[TB] FAIL ovf_wrap cnt=%h ovf=%b udf=%b tsr=%h exp cnt=00 ovf=1 udf=0 tsr=01", cnt, ovf, udf, tsr_status);
            failures++;
        end
        tcr = 8'h00;
        step(5);
        checks++;
        if (cnt !== 8'h00 || ovf !== 1'b1) begin
            $display("[TB] FAIL ovf_hold_disabled cnt=%h ovf=%b exp cnt=00 ovf=1", cnt, ovf);
            failures++;
        end
        flag_clr = 2'b01;
        step(1);
        flag_clr = 2'b00;
        checks++;
        if (ovf !== 1'b0 || tsr_status !== 8'h00) begin
            $display("[TB] FAIL ovf_clear ovf=%b tsr=%h exp ovf=0 tsr=00", ovf, tsr_status);
            failures++;
        end
    endtask

    task automatic test_underflow();
        do_reset();
        tdr = 8'h01;
        tcr = 8'h80;
        step(1);
        tcr = 8'h30;
        step(2);
        checks++;
        if (cnt !== 8'h00 || udf !== 1'b0) begin
            $display("[TB] FAIL udf_pre cnt=%h udf=%b exp cnt=00 udf=0", cnt, udf);
            failures++;
        end
        step(2);
        checks++;
        if (cnt !== 8'hFF || udf !== 1'b1 || ovf !== 1'b0 || tsr_status !== 8'h02) begin
            $display("[TB] FAIL udf_wrap cnt=%h udf=%b ovf=%b tsr=%h exp cnt=ff udf=1 ovf=0 tsr=02", cnt, udf, ovf, tsr_status);
            failures++;
        end
        tdr = 8'h00;
        tcr = 8'hB0;
        step(1);
        tcr = 8'h30;
        step(1);
        checks++;
        if (cnt !== 8'h00) begin
            $display("[TB] FAIL udf_reload cnt=%h exp=00", cnt);
            failures++;
        end
        flag_clr = 2'b10;
        step(1);
        flag_clr = 2'b00;
        checks++;
        if (cnt !== 8'hFF || udf !== 1'b1) begin
            $display("[TB] FAIL udf_set_wins cnt=%h udf=%b exp cnt=ff udf=1", cnt, udf);
            failures++;
        end
        tcr = 8'h20;
        flag_clr = 2'b10;
        step(1);
        flag_clr = 2'b00;
        checks++;
        if (udf !== 1'b0 || cnt !== 8'hFF) begin
            $display("[TB] FAIL udf_clear udf=%b cnt=%h exp udf=0 cnt=ff", udf, cnt);
            failures++;
        end
    endtask

    task automatic test_load_priority();
        do_reset();
        tcr = 8'h10;
        step(1);
        tdr = 8'h80;
        tcr = 8'h90;
        step(1);
        checks++;
        if (cnt !== 8'h80) begin
            $display("[TB] FAIL load_over_tick cnt=%h exp=80", cnt);
            failures++;
        end
        step(1);
        checks++;
        if (cnt !== 8'h80) begin
            $display("[TB] FAIL load_presc_restart cnt=%h exp=80", cnt);
            failures++;
        end
        step(1);
        checks++;
        if (cnt !== 8'h81) begin
            $display("[TB] FAIL load_first_tick cnt=%h exp=81", cnt);
            failures++;
        end
        step(8);
        checks++;
        if (cnt !== 8'h85 || ovf !== 1'b0 || udf !== 1'b0) begin
            $display("[TB] FAIL load_level_once cnt=%h ovf=%b udf=%b exp cnt=85 flags=0", cnt, ovf, udf);
            failures++;
        end
    endtask

    task automatic test_direction();
        do_reset();
        tdr = 8'h10;
        tcr = 8'h80;
        step(1);
        tcr = 8'h10;
        step(2);
        checks++;
        if (cnt !== 8'h11) begin
            $display("[TB] FAIL dir_up cnt=%h exp=11", cnt);
            failures++;
        end
        tcr = 8'h30;
        step(2);
        checks++;
        if (cnt !== 8'h10) begin
            $display("[TB] FAIL dir_down cnt=%h exp=10", cnt);
            failures++;
        end
    endtask

    task automatic test_irq();
        do_reset();
        tdr = 8'hFF;
        tcr = 8'h80;
        step(1);
        tcr = 8'h18;
        step(1);
        checks++;
        if (irq !== 1'b0) begin
            $display("[TB] FAIL irq_idle irq=%b exp=0", irq);
            failures++;
        end
        step(1);
        checks++;
        if (cnt !== 8'h00 || ovf !== 1'b1 || irq !== IRQ_ON) begin
            $display("[TB] FAIL irq_wrap cnt=%h ovf=%b irq=%b exp cnt=00 ovf=1 irq=%b", cnt, ovf, irq, IRQ_ON);
            failures++;
        end
        tcr = 8'h10;
        step(1);
        checks++;
        if (irq !== 1'b0 || ovf !== 1'b1) begin
            $display("[TB] FAIL irq_ie_clear irq=%b ovf=%b exp irq=0 ovf=1", irq, ovf);
            failures++;
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        PRESETn  = 1'b0;
        tcr      = 8'h00;
        tdr      = 8'h00;
        flag_clr = 2'b00;
        #12;
        PRESETn  = 1'b1;
        @(posedge PCLK);
        #1;
        test_reset();
        test_prescale();
        test_overflow();
        test_underflow();
        test_load_priority();
        test_direction();
        test_irq();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
